// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared overflow and saturation helpers for the pipelined CLA adder
package adder_pkg;

  typedef enum logic [1:0] {
    SAT_SMAX,
    SAT_SMIN,
    SAT_UMAX,
    SAT_ZERO
  } sat_kind_e;

  // cout is c[WIDTH], c_msb is the carry into the MSB (c[WIDTH-1])
  function automatic logic ov_rule(input logic is_signed, input logic sub,
                                   input logic c_msb, input logic cout);
    if (is_signed) return cout ^ c_msb;
    return sub ? ~cout : cout;
  endfunction

  // Signed overflow always saturates towards the sign of A
  function automatic sat_kind_e sat_kind(input logic is_signed, input logic sub,
                                         input logic a_msb);
    if (is_signed) return a_msb ? SAT_SMIN : SAT_SMAX;
    return sub ? SAT_ZERO : SAT_UMAX;
  endfunction

endpackage

// File: rtl/adder_cla_pipe_segment.sv
// rtl/adder_cla_pipe_segment.sv - combinational carry-lookahead over one SEG-bit segment
module cla_segment #(
  parameter int SEG = 16
) (
  input  logic [SEG-1:0] x,
  input  logic [SEG-1:0] y,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout,
  output logic           c_msb
);

  logic [SEG-1:0] g;
  logic [SEG-1:0] p;
  logic [SEG:0]   c;

  assign g = x & y;
  assign p = x ^ y;

  // Each carry is a group generate/propagate of bits [i:0] applied directly to cin
  always_comb begin
    logic gg;
    logic pp;
    gg   = 1'b0;
    pp   = 1'b1;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < SEG; i++) begin
      gg       = g[i] | (p[i] & gg);
      pp       = pp & p[i];
      c[i+1]   = gg | (pp & cin);
    end
  end

  assign s     = p ^ c[SEG-1:0];
  assign cout  = c[SEG];
  assign c_msb = c[SEG-1];

endmodule

// File: rtl/adder_cla_pipe.sv
// rtl/adder_cla_pipe.sv - STAGES-deep pipelined CLA add/sub with flow control, overflow and saturation
module adder_cla_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             is_signed,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ov
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  localparam logic [WIDTH-1:0] PAT_SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] PAT_SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] PAT_UMAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] PAT_ZERO = {WIDTH{1'b0}};

  logic advance;

  // Global stall: every rank moves together or none does
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             vi, subi, sgni, sati, ci;
    logic [WIDTH-1:0] ai, bi, si, merged;
    logic [SEG-1:0]   seg_s;
    logic             seg_cout, seg_cmsb;

    if (k == 0) begin : g_src
      assign vi   = in_valid;
      assign subi = sub;
      assign sgni = is_signed;
      assign sati = sat;
      assign ci   = sub;
      assign ai   = a;
      assign bi   = b;
      assign si   = '0;
    end else begin : g_src
      assign vi   = g_stage[k-1].g_reg.v_q;
      assign subi = g_stage[k-1].g_reg.sub_q;
      assign sgni = g_stage[k-1].g_reg.sgn_q;
      assign sati = g_stage[k-1].g_reg.sat_q;
      assign ci   = g_stage[k-1].g_reg.c_q;
      assign ai   = g_stage[k-1].g_reg.a_q;
      assign bi   = g_stage[k-1].g_reg.b_q;
      assign si   = g_stage[k-1].g_reg.s_q;
    end

    cla_segment #(.SEG(SEG)) u_seg (
      .x     (ai[k*SEG +: SEG]),
      .y     (bi[k*SEG +: SEG] ^ {SEG{subi}}),
      .cin   (ci),
      .s     (seg_s),
      .cout  (seg_cout),
      .c_msb (seg_cmsb)
    );

    always_comb begin
      merged               = si;
      merged[k*SEG +: SEG] = seg_s;
    end

    if (k < LAST) begin : g_reg
      logic             v_q, sub_q, sgn_q, sat_q, c_q;
      logic [WIDTH-1:0] a_q, b_q, s_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q   <= 1'b0;
          sub_q <= 1'b0;
          sgn_q <= 1'b0;
          sat_q <= 1'b0;
          c_q   <= 1'b0;
          a_q   <= '0;
          b_q   <= '0;
          s_q   <= '0;
        end else if (advance) begin
          v_q   <= vi;
          sub_q <= subi;
          sgn_q <= sgni;
          sat_q <= sati;
          c_q   <= seg_cout;
          a_q   <= ai;
          b_q   <= bi;
          s_q   <= merged;
        end
      end
    end else begin : g_out
      logic             raw_ov;
      logic [WIDTH-1:0] final_s;
      logic             v_q, c_q, ov_q;
      logic [WIDTH-1:0] s_q;

      assign raw_ov = ov_rule(sgni, subi, seg_cmsb, seg_cout);

      always_comb begin
        final_s = merged;
        if (sati && raw_ov) begin
          case (sat_kind(sgni, subi, ai[WIDTH-1]))
            SAT_SMAX: final_s = PAT_SMAX;
            SAT_SMIN: final_s = PAT_SMIN;
            SAT_UMAX: final_s = PAT_UMAX;
            default:  final_s = PAT_ZERO;
          endcase
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q  <= 1'b0;
          c_q  <= 1'b0;
          ov_q <= 1'b0;
          s_q  <= '0;
        end else if (advance) begin
          v_q  <= vi;
          c_q  <= seg_cout;
          ov_q <= raw_ov;
          s_q  <= final_s;
        end
      end

      assign out_valid = v_q;
      assign sum       = s_q;
      assign cout      = c_q;
      assign ov        = ov_q;
    end
  end

endmodule
